// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU commands, shift types,
// multiplier FSM states and status flag bit positions.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/exe_stage_mc_seq_multiplier.sv
// Iterative shift-add multiplier (low DATA_W bits of the product), one bit
// per cycle. Only built when EXE_MUL_EN is defined.
`ifdef EXE_MUL_EN
module seq_multiplier
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q, acc_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !abort) state_d = RUN;
            RUN: begin
                if (abort)                 state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: if (abort || ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplicand shifts left, multiplier shifts right; add on each set bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (state_q == IDLE && start && !abort) begin
            cnt_q <= '0;
            a_q   <= op_a;
            b_q   <= op_b;
            acc_q <= '0;
        end else if (state_q == RUN && !abort) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = acc_q;

endmodule
`endif

// File: rtl/exe_stage_mc.sv
// Registered execute stage: forwarding, val2 generation, ALU, branch target
// and EXE/MEM output register. Define EXE_MUL_EN to build the iterative multiplier.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              flush,
    input  logic              stall_in,
    input  logic              mem_read_enable_in,
    input  logic              mem_write_enable_in,
    input  logic              i_in,
    input  logic              s_in,
    input  logic              mul_in,
    input  logic [3:0]        status_in,
    input  logic [1:0]        sel_src1_in,
    input  logic [1:0]        sel_src2_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DATA_W-1:0] wb_value_in,
    input  logic [DATA_W-1:0] alu_res_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] branch_address_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [3:0]        status_out,
    output logic              status_we_out
);

    localparam int unsigned MSB   = DATA_W - 1;
    localparam int unsigned W1    = DATA_W + 1;
    localparam int unsigned EXT_W = (DATA_W > IMM_W) ? DATA_W : IMM_W;

    function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x, input int unsigned amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> (amt % DATA_W);
        return dbl[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] src1, src2, val2, alu_res, branch_addr;
    logic [DATA_W:0]   sum;
    logic [EXT_W-1:0]  imm_ext;
    logic [3:0]        cmd;
    logic              mem_op, n_f, z_f, c_f, v_f, nz_upd;
    logic              accept, mul_op, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_prod, mul_branch, mul_store;
    logic              mul_s;
    logic [1:0]        mul_cv;

    always_comb begin
        case (sel_src1_in)
            2'd1:    src1 = alu_res_in;
            2'd2:    src1 = wb_value_in;
            default: src1 = val_rn_in;
        endcase
        case (sel_src2_in)
            2'd1:    src2 = alu_res_in;
            2'd2:    src2 = wb_value_in;
            default: src2 = val_rm_in;
        endcase
    end

    assign mem_op = mem_read_enable_in | mem_write_enable_in;

    always_comb begin
        val2 = src2;
        if (mem_op) begin
            val2 = DATA_W'(shift_operand_in);
        end else if (i_in) begin
            val2 = ror_w(DATA_W'(shift_operand_in[7:0]), 32'({shift_operand_in[11:8], 1'b0}));
        end else begin
            case (shift_operand_in[6:5])
                SH_LSL:  val2 = src2 << shift_operand_in[11:7];
                SH_LSR:  val2 = src2 >> shift_operand_in[11:7];
                SH_ASR:  val2 = DATA_W'($signed(src2) >>> shift_operand_in[11:7]);
                default: val2 = ror_w(src2, 32'(shift_operand_in[11:7]));
            endcase
        end
    end

    assign cmd = mem_op ? CMD_ADD : exe_cmd_in;

    // C follows ARM convention: carry out of a + ~b + cin, i.e. 1 means no borrow.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        nz_upd  = 1'b1;
        c_f     = status_in[FLAG_C];
        v_f     = status_in[FLAG_V];
        case (cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, src1} + {1'b0, val2} + W1'(cmd == CMD_ADC && status_in[FLAG_C]);
                alu_res = sum[DATA_W-1:0];
                c_f     = sum[DATA_W];
                v_f     = (src1[MSB] == val2[MSB]) && (alu_res[MSB] != src1[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                sum     = {1'b0, src1} + {1'b0, ~val2} + W1'((cmd == CMD_SUB) || status_in[FLAG_C]);
                alu_res = sum[DATA_W-1:0];
                c_f     = sum[DATA_W];
                v_f     = (src1[MSB] != val2[MSB]) && (alu_res[MSB] != src1[MSB]);
            end
            CMD_AND: alu_res = src1 & val2;
            CMD_ORR: alu_res = src1 | val2;
            CMD_EOR: alu_res = src1 ^ val2;
            default: nz_upd = 1'b0;
        endcase
        n_f = nz_upd ? alu_res[MSB] : status_in[FLAG_N];
        z_f = nz_upd ? (alu_res == '0) : status_in[FLAG_Z];
    end

    assign imm_ext     = EXT_W'(signed'(imm_in));
    assign branch_addr = pc_in + (DATA_W'(imm_ext) << 2);

    assign ready_out = !stall_in && !mul_busy;
    assign accept    = valid_in && ready_out && !flush;
    assign mul_start = accept && mul_op;

`ifdef EXE_MUL_EN
    assign mul_op = mul_in;

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush),
        .ack     (!stall_in),
        .op_a    (src1),
        .op_b    (val2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Non-product results of a multiply are captured at accept and held until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_branch <= '0;
            mul_store  <= '0;
            mul_s      <= 1'b0;
            mul_cv     <= '0;
        end else if (mul_start) begin
            mul_branch <= branch_addr;
            mul_store  <= src2;
            mul_s      <= s_in;
            mul_cv     <= {status_in[FLAG_C], status_in[FLAG_V]};
        end
    end
`else
    logic unused_mul;
    assign unused_mul = mul_in;
    assign mul_op     = 1'b0;
    assign mul_busy   = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_prod   = '0;
    assign mul_branch = '0;
    assign mul_store  = '0;
    assign mul_s      = 1'b0;
    assign mul_cv     = '0;
`endif

    // EXE/MEM output register: flush beats stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out          <= 1'b0;
            alu_res_out        <= '0;
            branch_address_out <= '0;
            store_data_out     <= '0;
            status_out         <= '0;
            status_we_out      <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!stall_in) begin
            if (accept && !mul_op) begin
                valid_out          <= 1'b1;
                alu_res_out        <= alu_res;
                branch_address_out <= branch_addr;
                store_data_out     <= src2;
                status_out         <= {n_f, z_f, c_f, v_f};
                status_we_out      <= s_in;
            end else if (mul_done) begin
                valid_out          <= 1'b1;
                alu_res_out        <= mul_prod;
                branch_address_out <= mul_branch;
                store_data_out     <= mul_store;
                status_out         <= {mul_prod[MSB], (mul_prod == '0), mul_cv};
                status_we_out      <= mul_s;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised, registered execute stage for the ARM-subset pipeline. It takes decoded operands from the ID/EXE register and applies forwarding selection, val2 generation, ALU and branch-target computation. Results, flags and store data are written into an internal EXE/MEM output register with valid/ready handshaking. An optional iterative multiplier stalls the front end while it runs.

## Interface
- DATA_W, 32: datapath width (>= 16).
- IMM_W, 24: branch immediate width.
- clk  in  1  clock. Single clock domain; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- valid_in  in  1  decoded instruction present.
- ready_out  out  1  stage can accept; low while the multiplier is busy or the output register is stalled.
- flush  in  1  kill the in-flight and output-register instruction.
- stall_in  in  1  downstream (MEM) cannot accept.
- mem_read_enable_in, mem_write_enable_in, i_in, s_in, mul_in  in  1 each  LDR, STR, immediate, set-flags, multiply.
- status_in  in  4  current {N,Z,C,V}; C is the carry-in.
- sel_src1_in, sel_src2_in  in  2 each  forwarding select: 0 register, 1 alu_res_in, 2 wb_value_in, 3 reserved (selects register).
- exe_cmd_in  in  4  ALU command.
- shift_operand_in  in  12; imm_in  in  IMM_W.
- pc_in, val_rn_in, val_rm_in, wb_value_in, alu_res_in  in  DATA_W each.
- valid_out  out  1; alu_res_out, branch_address_out, store_data_out  out  DATA_W; status_out  out  4; status_we_out  out  1.

## Operation
- val1 and raw val2 are taken from the forwarding muxes.
- val2 generation:
  - Memory ops: zero-extended shift_operand[11:0].
  - i_in: imm8 rotated right by 2*rot4, where rot4 = shift_operand[11:8].
  - Otherwise: Rm shifted by shift_imm = shift_operand[11:7], with type [6:5] = LSL/LSR/ASR/ROR.
- ALU commands:
  - 0001 MOV; 1001 MVN.
  - 0010 ADD; 0011 ADC.
  - 0100 SUB/CMP; 0101 SBC.
  - 0110 AND/TST; 0111 ORR; 1000 EOR.
  - Any other code gives result 0 with flags unchanged.
  - Memory ops force ADD.
- Flags:
  - N is the result MSB; Z is set when the result is 0.
  - C and V are updated only by arithmetic ops; logic ops keep C and V from status_in.
  - MUL updates N and Z only.
- branch_address = pc_in + (sign-extend(imm) << 2), truncated to DATA_W.
- store_data_out is the forwarded val2 source before val2 generation.
- Accept condition: valid_in && ready_out.
  - Non-multiply op: computed combinationally and captured into the output register on the accepting edge.
  - mul_in op: val1 and val2 are latched and the multiplier starts.
- Multiplier FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on accept of a multiply.
  - RUN: shift-add, one bit per cycle, DATA_W cycles; produces the low DATA_W bits of the product.
  - RUN -> DONE when the count expires.
  - DONE -> IDLE when the result is written into the output register, which requires !stall_in.
  - ready_out is low in RUN and DONE.
- Output register:
  - Holds all outputs while stall_in is asserted.
  - ready_out = !stall_in && FSM == IDLE.
- status_we_out = s_in of the registered instruction.

## Timing
- Reset:
  - valid_out = 0; all data outputs = 0; status_out = 0; status_we_out = 0.
  - FSM = IDLE; ready_out = 1 in the cycle after rst deasserts.
- Non-multiply op: latency 1 (accept at edge k, valid_out high after edge k). Throughput is one op per cycle.
- Multiply: accept at edge k; valid_out rises after edge k+DATA_W+1, provided stall_in stays low.
- stall_in high: no accept; output register frozen; a multiplier in RUN keeps running, then waits in DONE.
- flush:
  - Clears valid_out on the next edge.
  - Forces the FSM to IDLE, discarding any partial product.
  - Overrides stall_in and a simultaneous valid_in; the flushing cycle accepts nothing.
- rst asserted mid-multiply: behaves as a flush and also zeroes all outputs.
- Forwarding inputs are sampled only on the accept edge; changes to them during RUN are ignored.

## Configuration
- EXE_MUL_EN defined: multiplier and FSM are compiled in; mul_in is honoured.
- EXE_MUL_EN not defined:
  - No multiplier logic; the FSM is permanently IDLE.
  - mul_in is ignored and the op executes as exe_cmd_in.
  - ready_out = !stall_in.

## Structure
- Shared package exe_pkg holds:
  - ALU command localparams (CMD_MOV … CMD_EOR).
  - Shift-type constants.
  - FSM state enum {IDLE, RUN, DONE}.
  - Flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module: seq_multiplier. It owns the FSM and the counter and handles start/done/abort handshakes, so the top-level file keeps the datapath and output register.
- val2 generation and the ALU stay as existing combinational instances.

## Test plan
- ADD reg: val_rn=5, val_rm=7, sel=0, cmd=0010, s=1 -> one cycle later alu_res=12, status={0,0,0,0}, valid_out=1.
- Forward + flags: sel_src1=1, alu_res_in=0x7FFFFFFF, val2=1, ADD -> result 0x80000000, N=1, V=1, C=0.
- Immediate rotate: i=1, shift_operand=0x4FF, MOV -> 0xFF000000. Branch: pc=0x100, imm=0xFFFFFF -> branch_address 0xFC.
- Multiply (EXE_MUL_EN): 6×7 -> ready_out low for 33 cycles, then alu_res=42, valid_out=1. With the macro undefined: mul_in ignored, latency 1.
- Stall: stall_in high for 3 cycles after a result -> outputs held, ready_out=0; the next op is accepted on the cycle stall_in drops.
- Flush during RUN, and rst mid-multiply -> valid_out=0 and ready_out=1 on the following cycle; no stale product ever appears.
